// File: rtl/fifo_param.sv
// Single-clock synchronous FIFO with registered read data, occupancy count,
// threshold flags and sticky overflow/underflow indicators.
module fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_in,
  input  logic                  we,
  input  logic                  re,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] fifo_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  rd_ok;
  logic                  wr_ok;

  // A full FIFO still takes a write when a read frees the oldest slot.
  assign rd_ok = re && !empty;
  assign wr_ok = we && (!full || re);

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      fifo_out  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) begin
        fifo_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + PTR_ONE;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      // A new error event wins over a clear in the same cycle.
      if (we && full && !re) overflow <= 1'b1;
      else if (clr_err)      overflow <= 1'b0;
      if (re && empty)       underflow <= 1'b1;
      else if (clr_err)      underflow <= 1'b0;
    end
  end

  // Storage is deliberately not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (rst && wr_ok) mem[wr_ptr] <= fifo_in;
  end

endmodule

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, pointer width; DEPTH = 2**ADDR_WIDTH entries, all usable.
REQ-003 SHALL have parameter AF_LEVEL, default 12, almost-full threshold in entries (1..DEPTH).
REQ-004 SHALL have parameter AE_LEVEL, default 4, almost-empty threshold in entries (0..DEPTH-1).
REQ-005 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port fifo_in  input  DATA_WIDTH  write data.
REQ-008 SHALL have port we  input  1  write request.
REQ-009 SHALL have port re  input  1  read request.
REQ-010 SHALL have port clr_err  input  1  clears sticky overflow/underflow.
REQ-011 SHALL have port fifo_out  output  DATA_WIDTH  registered read data.
REQ-012 SHALL have port count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-013 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-014 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-015 Read accepted SHALL be re && !empty; write accepted SHALL be we && (!full || re).
REQ-016 Accepted write SHALL store fifo_in at wr_ptr and advance wr_ptr by 1, modulo DEPTH.
REQ-017 Accepted read SHALL load mem[rd_ptr] into fifo_out at that edge (1-cycle latency) and advance rd_ptr by 1, modulo DEPTH.
REQ-018 fifo_out SHALL hold its value on any cycle without an accepted read.
REQ-019 count SHALL +1 on write-only, -1 on read-only, and stay unchanged on both or neither.
REQ-020 Full with we and re SHALL accept both: oldest word read, new word written into freed slot, count stays DEPTH.
REQ-021 Empty with we and re SHALL accept write only, reject read, set underflow; count becomes 1, fifo_out unchanged.
REQ-022 full = (count == DEPTH); empty = (count == 0); flags SHALL be combinational from registered count.
REQ-023 almost_full = (count >= AF_LEVEL); almost_empty = (count <= AE_LEVEL).
REQ-024 overflow SHALL set at an edge where we && full && !re; write discarded, pointers and memory unchanged.
REQ-025 underflow SHALL set at an edge where re && empty; pointers unchanged.
REQ-026 overflow/underflow SHALL stay set until an edge with clr_err=1; set condition in the same cycle SHALL take priority over clear.
REQ-027 Pointer wrap from DEPTH-1 to 0 SHALL be seamless, with no lost or duplicated word.

Reset
REQ-028 At an edge with rst=0: wr_ptr, rd_ptr, count SHALL be 0, fifo_out 0, overflow and underflow 0; requests that cycle SHALL be ignored.
REQ-029 After reset: empty=1, almost_empty=1, full=0, almost_full=0 (AF_LEVEL>=1).
REQ-030 Memory array SHALL NOT be reset; reset mid-operation SHALL discard all stored words.

Verification (bench: DATA_WIDTH=8, ADDR_WIDTH=2, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1)
REQ-031 Write 0xA1,0xA2,0xA3,0xA4, then read 4 -> fifo_out 0xA1..0xA4 one cycle after each read; count 1,2,3,4 then 3,2,1,0; almost_full at count 3; full at 4.
REQ-032 Full FIFO, write 0xFF alone -> overflow=1, count=4, subsequent reads return original 4 words; clr_err=1 clears overflow.
REQ-033 Full FIFO, we=re=1 with 0x55 -> oldest word out, count stays 4, 0x55 returned as the 4th subsequent read.
REQ-034 Empty FIFO, we=re=1 with 0x3C -> underflow=1, count=1, fifo_out unchanged; next read returns 0x3C.
REQ-035 10 write/read pairs of 0x10..0x19 across pointer wrap -> outputs in order, no loss; then rst=0 for one cycle with count=2 -> count=0, empty=1, fifo_out=0, flags cleared.
